// File: rtl/img_pkg.sv
// Shared image-stream types: RGB565 pixel, stream tags, reader FSM states and colour-bar palette.
package img_pkg;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int PIX_W = R_W + G_W + B_W;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } pixel_t;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
  } tag_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_DRAIN
  } state_t;

  localparam int NUM_BARS = 8;
  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic pixel_t bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return pixel_t'(c);
  endfunction

endpackage

// File: rtl/frame_tag_pipe.sv
// Fixed-depth delay line that carries stream tags alongside the frame-buffer read latency.
module frame_tag_pipe #(
  parameter int RD_LAT = 2,
  parameter int W      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[RD_LAT-1];

endmodule

// File: rtl/frame_pixel_reader.sv
// Raster pixel source: streams one RGB565 frame from a fixed-latency frame-buffer read port.
// Defining TEST_PATTERN_EN adds a pattern_sel input selecting an internal 8-bar colour generator.
module frame_pixel_reader
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int HBLANK_CYC = 16,
  parameter int RD_LAT     = 2,
  parameter int ADDR_W     = 19,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [15:0]       mem_rd_data,
  output logic [15:0]       pixel_out,
  output logic              data_valid_out,
  output logic              sof_out,
  output logic              eol_out
);

  localparam int XW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int HW    = (HBLANK_CYC > 1) ? $clog2(HBLANK_CYC) : 1;
  localparam int DW    = $clog2(RD_LAT + 1);
  localparam int TAG_W = $bits(tag_t);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [HW-1:0] HB_LAST = HW'(HBLANK_CYC - 1);
  localparam logic [DW-1:0] DR_LAST = DW'(RD_LAT);
`ifdef TEST_PATTERN_EN
  localparam int BAR_W  = IMG_WIDTH / NUM_BARS;
  localparam int BXW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BXW-1:0] BX_LAST = BXW'(BAR_W - 1);
  localparam int PIPE_W = TAG_W + PIX_W;
`else
  localparam int PIPE_W = TAG_W;
`endif

  state_t            state, state_nxt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [HW-1:0]     hb_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [ADDR_W-1:0] addr;
  logic              accept, issue, last_x, last_y, hb_done, drain_done;
  tag_t              tag_in, tag_out;
  logic [PIPE_W-1:0] pipe_in, pipe_out;
  logic              pat_active;

`ifdef TEST_PATTERN_EN
  logic              pat_mode;
  logic [BXW-1:0]    bar_x;
  logic [2:0]        bar_idx;
  pixel_t            pat_pix, pat_pix_out;
  assign pat_active = pat_mode;
`else
  assign pat_active = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    last_x     = (x == X_LAST);
    last_y     = (y == Y_LAST);
    hb_done    = (hb_cnt == HB_LAST);
    drain_done = (drain_cnt == DR_LAST);
    accept     = 1'b0;
    issue      = (state == S_ACTIVE);
    case (state)
      S_IDLE: begin
        accept = start && !frame_done;
        if (accept) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (last_x) begin
          if (last_y)               state_nxt = S_DRAIN;
          else if (HBLANK_CYC != 0) state_nxt = S_HBLANK;
        end
      end
      S_HBLANK: if (hb_done)    state_nxt = S_ACTIVE;
      S_DRAIN:  if (drain_done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    mem_rd_en     = issue && !pat_active;
    tag_in.valid  = issue;
    tag_in.sof    = issue && (x == '0) && (y == '0);
    tag_in.eol    = issue && last_x;
`ifdef TEST_PATTERN_EN
    pat_pix       = bar_colour(bar_idx);
    pipe_in       = {tag_in, pat_pix};
    pat_pix_out   = pixel_t'(pipe_out[PIX_W-1:0]);
`else
    pipe_in       = tag_in;
`endif
    tag_out       = tag_t'(pipe_out[PIPE_W-1 -: TAG_W]);
  end

  // Sequencer: the address is a running counter so no x*width product is ever formed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      hb_cnt     <= '0;
      drain_cnt  <= '0;
      addr       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            addr <= ADDR_W'(BASE_ADDR);
            x    <= '0;
            y    <= '0;
          end
        end
        S_ACTIVE: begin
          addr      <= addr + ADDR_W'(1);
          hb_cnt    <= '0;
          drain_cnt <= '0;
          if (last_x) begin
            x <= '0;
            if (!last_y && HBLANK_CYC == 0) y <= y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
        S_HBLANK: begin
          hb_cnt <= hb_cnt + HW'(1);
          if (hb_done) y <= y + YW'(1);
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_done) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TEST_PATTERN_EN
  // Bar position is tracked incrementally per line, mirroring the address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_mode <= 1'b0;
      bar_x    <= '0;
      bar_idx  <= '0;
    end else if (accept) begin
      pat_mode <= pattern_sel;
      bar_x    <= '0;
      bar_idx  <= '0;
    end else if (issue) begin
      if (last_x) begin
        bar_x   <= '0;
        bar_idx <= '0;
      end else if (bar_x == BX_LAST) begin
        bar_x   <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_x <= bar_x + BXW'(1);
      end
    end
  end
`endif

  frame_tag_pipe #(.RD_LAT(RD_LAT), .W(PIPE_W)) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out      <= '0;
      data_valid_out <= 1'b0;
      sof_out        <= 1'b0;
      eol_out        <= 1'b0;
    end else begin
      data_valid_out <= tag_out.valid;
      sof_out        <= tag_out.sof;
      eol_out        <= tag_out.eol;
      if (tag_out.valid) begin
`ifdef TEST_PATTERN_EN
        if (pat_mode) pixel_out <= pat_pix_out;
        else          pixel_out <= mem_rd_data;
`else
        pixel_out <= mem_rd_data;
`endif
      end
    end
  end

  assign mem_rd_addr = addr;

endmodule
